// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and default sizes for the bit serializer
package serializer_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel word input plus serial stream and status outputs
interface bit_serializer_if
    import serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     seq;
    logic                     seq_valid;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    modport master (
        output in_data, in_valid,
        input  in_ready, seq, seq_valid, busy, fifo_count
    );
    modport slave (
        input  in_data, in_valid,
        output in_ready, seq, seq_valid, busy, fifo_count
    );
endinterface

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous word FIFO; pushes when full and pops when empty are ignored
module ser_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;
    // full is judged on the pre-pop count, so a full FIFO never takes a word
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    // storage needs no reset; stale words are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: buffers parallel words and emits them MSB-first as a gap-free bit stream
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int CW = $clog2(DATA_W);
    state_t                 state;
    state_t                 state_n;
    logic [DATA_W-1:0]      sh;
    logic [DATA_W-1:0]      sh_n;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_n;
    logic [DATA_W-1:0]      head;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    ser_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .din   (bus.in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign bus.in_ready   = !full;
    assign bus.fifo_count = count;
    assign bus.seq        = sh[DATA_W-1];
    assign bus.seq_valid  = state == SHIFT;
    assign bus.busy       = state == SHIFT || !empty;
    // state, shift register and bit counter; seq/seq_valid come straight from these
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
        end
    end
    // load on a pop, otherwise shift; the register is cleared on return to IDLE so seq reads 0
    always_comb begin
        pop     = 1'b0;
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        if (state == SHIFT && cnt != '0) begin
            sh_n  = sh << 1;
            cnt_n = cnt - 1'b1;
        end else if (!empty) begin
            pop     = 1'b1;
            state_n = SHIFT;
            sh_n    = head;
            cnt_n   = CW'(DATA_W - 1);
        end else begin
            state_n = IDLE;
            sh_n    = '0;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for the bit serializer
module tb_bit_serializer;
    import serializer_pkg::*;
    localparam int DW = 8;
    localparam int DP = 4;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];
    always #5 clk = ~clk;
    bit_serializer_if #(.DATA_W(DW), .DEPTH(DP)) bus();
    bit_serializer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.seq_valid !== 1'b0 || bus.seq !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: seq_valid=%b seq=%b busy=%b required 0 0 0", bus.seq_valid, bus.seq, bus.busy);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_fifo: in_ready=%b fifo_count=%0d required 1 0", bus.in_ready, bus.fifo_count);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        logic e;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = c == 0;
            bus.in_data = 8'hB0;
            @(negedge clk);
            n_cmp++;
            if (bus.seq_valid !== (c >= 2 && c <= 9)) begin
                n_bad++;
                $display("FAIL single_valid c%0d: seq_valid=%b required %b", c, bus.seq_valid, c >= 2 && c <= 9);
            end
            if (bus.seq_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL single_bit c%0d: unexpected bit %b", c, bus.seq);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.seq !== e) begin
                        n_bad++;
                        $display("FAIL single_bit c%0d: seq=%b required %b", c, bus.seq, e);
                    end
                end
            end
            if (c >= 10) begin
                n_cmp++;
                if (bus.busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_busy c%0d: busy=%b required 0", c, bus.busy);
                end
            end
            if (bus.in_valid && bus.in_ready) push_word(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic       e;
        logic [3:0] win = '0;
        int         hits = 0;
        logic [DW-1:0] words [2] = '{8'hBB, 8'h0B};
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = c < 2;
            bus.in_data = words[c < 2 ? c : 0];
            @(negedge clk);
            n_cmp++;
            if (bus.seq_valid !== (c >= 2 && c <= 17)) begin
                n_bad++;
                $display("FAIL b2b_valid c%0d: seq_valid=%b required %b", c, bus.seq_valid, c >= 2 && c <= 17);
            end
            if (bus.seq_valid) begin
                win = {win[2:0], bus.seq};
                if (win == 4'b1011) hits++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_bit c%0d: unexpected bit %b", c, bus.seq);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.seq !== e) begin
                        n_bad++;
                        $display("FAIL b2b_bit c%0d: seq=%b required %b", c, bus.seq, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) push_word(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (hits != 3) begin
            n_bad++;
            $display("FAIL b2b_detect: hits=%0d required 3", hits);
        end
    endtask

    task automatic test_overflow;
        logic e;
        int   idx = 0;
        logic saw_full = 1'b0;
        for (int c = 0; c < 120 && !(idx == 6 && exp_q.size() == 0 && !bus.busy); c++) begin
            bus.in_valid = idx < 6;
            bus.in_data = DW'(idx + 1);
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== (bus.fifo_count < DP) || bus.fifo_count > DP) begin
                n_bad++;
                $display("FAIL ovf_ready c%0d: in_ready=%b fifo_count=%0d required ready=(count<%0d)", c, bus.in_ready, bus.fifo_count, DP);
            end
            if (bus.fifo_count == DP) saw_full = 1'b1;
            if (bus.seq_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ovf_bit c%0d: unexpected bit %b", c, bus.seq);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.seq !== e) begin
                        n_bad++;
                        $display("FAIL ovf_bit c%0d: seq=%b required %b", c, bus.seq, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                push_word(bus.in_data);
                idx++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (idx != 6 || exp_q.size() != 0 || !saw_full) begin
            n_bad++;
            $display("FAIL ovf_done: accepted=%0d pending_bits=%0d saw_full=%b required 6 0 1", idx, exp_q.size(), saw_full);
        end
    endtask

    task automatic test_reset_mid;
        logic e;
        int   stale = 0;
        logic [DW-1:0] words [3] = '{8'hF0, 8'hAA, 8'h55};
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = c < 3;
            bus.in_data = words[c < 3 ? c : 0];
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                n_cmp++;
                if (bus.fifo_count !== 3'd2) begin
                    n_bad++;
                    $display("FAIL rmid_queued: fifo_count=%0d required 2", bus.fifo_count);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (bus.seq_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rmid_reset: seq_valid=%b fifo_count=%0d in_ready=%b busy=%b required 0 0 1 0", bus.seq_valid, bus.fifo_count, bus.in_ready, bus.busy);
                end
            end else if (bus.seq_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rmid_bit c%0d: unexpected bit %b", c, bus.seq);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.seq !== e) begin
                        n_bad++;
                        $display("FAIL rmid_bit c%0d: seq=%b required %b", c, bus.seq, e);
                    end
                end
            end
            if (c < 5 && bus.in_valid && bus.in_ready) push_word(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.seq_valid || bus.busy) stale++;
            tick();
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++;
            $display("FAIL rmid_stale: active cycles after reset=%0d required 0", stale);
        end
    endtask

    task automatic test_wrap;
        logic e;
        int   idx = 0;
        int   over = 0;
        for (int c = 0; c < 600 && !(idx == 3 * DP && exp_q.size() == 0 && !bus.busy); c++) begin
            bus.in_valid = idx < 3 * DP && $urandom_range(0, 2) != 0;
            bus.in_data = DW'($urandom);
            @(negedge clk);
            if (bus.fifo_count > DP) over++;
            if (bus.seq_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap_bit c%0d: unexpected bit %b", c, bus.seq);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.seq !== e) begin
                        n_bad++;
                        $display("FAIL wrap_bit c%0d: seq=%b required %b", c, bus.seq, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                push_word(bus.in_data);
                idx++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (idx != 3 * DP || exp_q.size() != 0 || over != 0) begin
            n_bad++;
            $display("FAIL wrap_done: accepted=%0d pending_bits=%0d over_depth=%0d required %0d 0 0", idx, exp_q.size(), over, 3 * DP);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
